// File: rtl/mem_access_unit_if.sv
// Bundles the request, data-memory and result signals of mem_access_unit.
// master: the side that drives requests and answers memory cycles.
// slave: the load/store unit itself.
interface mem_access_unit_if;
  // Request side
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_code;
  logic [31:0] addr;
  logic [31:0] wdata;
  // Data-memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  // Result side
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_err;
  logic [1:0]  err_code;

  modport master (
    output op_valid, op_code, addr, wdata, mem_ack, mem_rdata,
    input  op_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  res_valid, res_data, res_err, err_code
  );

  modport slave (
    input  op_valid, op_code, addr, wdata, mem_ack, mem_rdata,
    output op_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output res_valid, res_data, res_err, err_code
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: runs one data-memory transaction per accepted op and returns
// an extended load result or a store completion. Misaligned and illegal ops are
// reported without touching memory.
// Optional feature: define MEMU_TIMEOUT_EN to abort a request that is not
// acknowledged within MEM_TIMEOUT cycles (err_code 11).
module mem_access_unit #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst_n,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        store_q;

`ifdef MEMU_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);
  logic [7:0]  cnt_q;
`endif

  logic        is_store;
  logic [1:0]  size;
  logic        legal;
  logic        misaligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;

  assign bus.op_ready = (state_q == StIdle);

  // Decode the incoming op: legality, alignment, byte enables and store lanes
  always_comb begin
    is_store   = bus.op_code[3];
    size       = bus.op_code[1:0];
    legal      = bus.op_code inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                     4'b0101, 4'b1000, 4'b1001, 4'b1010};
    misaligned = 1'b0;
    case (size)
      2'b01:   misaligned = bus.addr[0];
      2'b10:   misaligned = (bus.addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    be_d    = 4'b1111;
    wdata_d = '0;
    if (is_store) begin
      case (size)
        2'b00: begin
          be_d    = 4'b0001 << bus.addr[1:0];
          wdata_d = {4{bus.wdata[7:0]}};
        end
        2'b01: begin
          be_d    = bus.addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{bus.wdata[15:0]}};
        end
        default: wdata_d = bus.wdata;
      endcase
    end
  end

  // Select the addressed lane from read data and extend it
  always_comb begin
    ld_byte  = bus.mem_rdata[{lane_q, 3'b000} +: 8];
    ld_half  = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_ext = bus.mem_rdata;
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  // Control FSM with registered bus and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      lane_q        <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      store_q       <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_err   <= 1'b0;
      bus.err_code  <= 2'b00;
`ifdef MEMU_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.op_valid) begin
            if (!legal || misaligned) begin
              // Illegal wins over misaligned; neither reaches memory
              state_q       <= StDone;
              bus.res_valid <= 1'b1;
              bus.res_err   <= 1'b1;
              bus.res_data  <= '0;
              bus.err_code  <= !legal ? 2'b10 : 2'b01;
            end else begin
              state_q       <= StReq;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= is_store;
              bus.mem_addr  <= {bus.addr[31:2], 2'b00};
              bus.mem_be    <= be_d;
              bus.mem_wdata <= wdata_d;
              lane_q        <= bus.addr[1:0];
              size_q        <= size;
              uns_q         <= bus.op_code[2];
              store_q       <= is_store;
`ifdef MEMU_TIMEOUT_EN
              cnt_q         <= '0;
`endif
            end
          end
        end
        StReq: begin
          if (bus.mem_ack) begin
            state_q       <= StDone;
            bus.mem_req   <= 1'b0;
            bus.res_valid <= 1'b1;
            bus.res_err   <= 1'b0;
            bus.err_code  <= 2'b00;
            bus.res_data  <= store_q ? '0 : load_ext;
          end
`ifdef MEMU_TIMEOUT_EN
          // cnt_q holds the number of REQ cycles already completed
          else if (cnt_q == TimeoutLast) begin
            state_q       <= StDone;
            bus.mem_req   <= 1'b0;
            bus.res_valid <= 1'b1;
            bus.res_err   <= 1'b1;
            bus.err_code  <= 2'b11;
            bus.res_data  <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        StDone: begin
          state_q       <= StIdle;
          bus.res_valid <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a byte-level model.
module tb_mem_access_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_TIMEOUT(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: what the op should do, from opcode/address/data rules alone
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, output logic [1:0] err, output logic [3:0] be,
                       output logic [31:0] mwd, output logic [31:0] res);
    int     n;
    int     lane;
    longint v;
    longint full;
    n    = 1 << op[1:0];
    lane = int'(a[1:0]);
    err  = 2'b00;
    be   = 4'hf;
    mwd  = '0;
    res  = '0;
    if (!(op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA})) begin
      err = 2'b10;
    end else if ((int'(a[1:0]) % n) != 0) begin
      err = 2'b01;
    end else if (op[3]) begin
      be = 4'(((1 << n) - 1) << lane);
      for (int i = 0; i < 4; i++) mwd[8*i +: 8] = 8'(wd >> (8 * (i % n)));
    end else begin
      full = longint'(64'd1) << (8 * n);
      v    = longint'({32'd0, rd} >> (8 * lane)) & (full - 1);
      if (!op[2] && v >= (full / 2)) v = v - full;
      res = 32'(v);
    end
  endtask

  task automatic accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
    int t;
    t = 0;
    while (bus.op_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("op_ready_before_accept", 32'(bus.op_ready), 32'd1);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.addr     = a;
    bus.wdata    = wd;
    @(posedge clk);
    #1;
    // Scramble inputs: the unit must have sampled them at the edge
    bus.op_valid = 1'b0;
    bus.op_code  = 4'($urandom);
    bus.addr     = $urandom;
    bus.wdata    = $urandom;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int wait_n);
    logic [1:0]  e_err;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_res;
    model(op, a, wd, rd, e_err, e_be, e_wd, e_res);
    @(negedge clk);
    accept(op, a, wd);
    if (e_err != 2'b00) begin
      @(negedge clk);
      chk("err_no_req", 32'(bus.mem_req), 32'd0);
      chk("err_res_valid", 32'(bus.res_valid), 32'd1);
      chk("err_res_err", 32'(bus.res_err), 32'd1);
      chk("err_code", 32'(bus.err_code), 32'(e_err));
      chk("err_res_data", bus.res_data, 32'd0);
    end else begin
      for (int i = 0; i <= wait_n; i++) begin
        @(negedge clk);
        chk("req_high", 32'(bus.mem_req), 32'd1);
        chk("req_busy", 32'(bus.op_ready), 32'd0);
        chk("req_no_res", 32'(bus.res_valid), 32'd0);
        chk("mem_we", 32'(bus.mem_we), 32'(op[3]));
        chk("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
        chk("mem_be", 32'(bus.mem_be), 32'(e_be));
        chk("mem_wdata", bus.mem_wdata, e_wd);
        if (i == wait_n) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rd;
        end else begin
          bus.mem_rdata = $urandom;
        end
        @(posedge clk);
        #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
      end
      @(negedge clk);
      chk("done_req_low", 32'(bus.mem_req), 32'd0);
      chk("done_res_valid", 32'(bus.res_valid), 32'd1);
      chk("done_res_err", 32'(bus.res_err), 32'd0);
      chk("done_err_code", 32'(bus.err_code), 32'd0);
      chk("done_res_data", bus.res_data, e_res);
    end
    @(negedge clk);
    chk("pulse_one_cycle", 32'(bus.res_valid), 32'd0);
    chk("ready_after_done", 32'(bus.op_ready), 32'd1);
    chk("res_data_held", bus.res_data, e_res);
  endtask

  task automatic idle_ack();
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_ignored_ready", 32'(bus.op_ready), 32'd1);
    chk("idle_ack_no_res", 32'(bus.res_valid), 32'd0);
    chk("idle_ack_no_req", 32'(bus.mem_req), 32'd0);
  endtask

  logic [3:0] legal_ops [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    n_cmp         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_code   = '0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    #1;
    chk("rst_op_ready", 32'(bus.op_ready), 32'd1);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst_err_code", 32'(bus.err_code), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(4'h0, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 0);   // LB, zero wait
    run_op(4'h5, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 3);   // LHU, 3 wait cycles
    run_op(4'h8, 32'h0000_0011, 32'h1234_56A5, 32'h0, 1);   // SB
    run_op(4'h2, 32'h0000_0006, 32'h0, 32'h0, 0);           // LW misaligned
    run_op(4'h3, 32'h0000_0000, 32'h0, 32'h0, 0);           // illegal
    run_op(4'h7, 32'h0000_0003, 32'h0, 32'h0, 0);           // illegal beats misaligned
    run_op(4'h9, 32'h0000_0042, 32'hCAFE_D00D, 32'h0, 2);   // SH upper half
    run_op(4'hA, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);   // SW
    run_op(4'h1, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0);   // LH sign from upper half
    idle_ack();

    // Reset in the middle of an SW request
    @(negedge clk);
    accept(4'hA, 32'h0000_0200, 32'h0BAD_F00D);
    @(negedge clk);
    chk("rst_mid_req_high", 32'(bus.mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_drop", 32'(bus.mem_req), 32'd0);
    chk("rst_mid_ready", 32'(bus.op_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_no_res", 32'(bus.res_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.op_ready), 32'd1);
    chk("post_rst_no_res", 32'(bus.res_valid), 32'd0);
    run_op(4'h2, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 1);

`ifdef MEMU_TIMEOUT_EN
    // No ack: request must last exactly 16 cycles, then time out
    @(negedge clk);
    accept(4'h2, 32'h0000_0400, 32'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("to_req_high", 32'(bus.mem_req), 32'd1);
    end
    @(negedge clk);
    chk("to_req_low", 32'(bus.mem_req), 32'd0);
    chk("to_res_valid", 32'(bus.res_valid), 32'd1);
    chk("to_res_err", 32'(bus.res_err), 32'd1);
    chk("to_err_code", 32'(bus.err_code), 32'd3);
    chk("to_res_data", bus.res_data, 32'd0);
    @(negedge clk);
    chk("to_ready", 32'(bus.op_ready), 32'd1);
    // Ack on the 16th cycle wins
    run_op(4'h2, 32'h0000_0404, 32'h0, 32'h2468_ACE0, 15);
`endif

    // Randomized ops
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 5) == 0) op = 4'($urandom);
      else op = legal_ops[$urandom_range(0, 7)];
      a = $urandom;
      if ($urandom_range(0, 3) != 0 && op[1:0] != 2'b11) a = a & ~32'((1 << op[1:0]) - 1);
      run_op(op, a, $urandom, $urandom, $urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) idle_ack();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit for the execute-to-memory boundary of the MIPS core. It takes the effective address produced by the ALU's data-memory address output, together with the load/store opcode and store data. It then runs one data-memory transaction over a req/ack handshake and returns a sign- or zero-extended load result, or a completion for stores. Misaligned accesses, illegal opcodes and (optionally) memory timeouts are reported as errors instead of issuing or completing a bus transaction.

## Interface
Parameters:
- MEM_TIMEOUT, 16: max cycles mem_req may stay high without mem_ack (only with MEMU_TIMEOUT_EN); legal 2..255.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_valid  in  1  request present
- op_ready  out  1  unit idle, request accepted when op_valid && op_ready at rising edge
- op_code  in  4  [3]=store, [2]=unsigned, [1:0]=size (00 byte, 01 half, 10 word); legal: 0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW
- addr  in  32  effective byte address (ALU result)
- wdata  in  32  store data (rt), low bits significant
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_be  out  4  byte enables, bit i = bits [8i+7:8i]
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  transaction complete; mem_rdata valid same cycle
- mem_rdata  in  32  read data
- res_valid  out  1  one-cycle completion pulse
- res_data  out  32  extended load data; 0 for stores and errors
- res_err  out  1  error flag, valid with res_valid
- err_code  out  2  01 misaligned, 10 illegal op, 11 timeout, 00 none

## Operation
- States: IDLE, REQ, DONE. op_ready = (state == IDLE).
- IDLE, accept, legal and aligned: register mem_addr/mem_we/mem_be/mem_wdata, go REQ.
- IDLE, accept, illegal opcode: go DONE, err 10. Illegal has priority over misaligned.
- IDLE, accept, misaligned (half with addr[0]=1, word with addr[1:0]≠0): go DONE, err 01. No mem_req is issued.
- REQ: mem_req=1. mem_addr, mem_we, mem_be and mem_wdata are stable. On mem_ack, capture the load result and go DONE.
- DONE: res_valid=1 for one cycle, then go IDLE. res_data, res_err and err_code hold until the next DONE.
- Little-endian lanes, lane = addr[1:0]:
  - LB/LBU: byte lane, sign/zero-extended to 32.
  - LH/LHU: lane 0 → [15:0], lane 2 → [31:16].
  - LW: full word.
- Stores:
  - SB: mem_be = 1<<addr[1:0], mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_be = 0011 or 1100, mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 1111.
- Loads drive mem_be = 1111, mem_we=0, mem_wdata=0.
- mem_ack outside REQ is ignored.

## Timing
- Reset (async assert): state IDLE, all outputs 0 except op_ready=1. mem_req drops immediately.
- Reset mid-transaction aborts the operation; no res_valid is produced for it.
- Legal op accepted at edge E0: mem_req is high from E0. Ack sampled at edge Ek (k≥1) gives res_valid in the cycle after Ek; op_ready returns the cycle after that.
- Zero-wait memory (ack in first REQ cycle): res_valid 2 cycles after accept; minimum 3 cycles per operation.
- Error op accepted at E0: res_valid in the cycle after E0, with no memory cycle.
- op_valid while busy: op_ready=0; requester holds its inputs. Inputs are sampled only at accept.

## Configuration
- MEMU_TIMEOUT_EN defined:
  - An 8-bit counter counts REQ cycles.
  - If mem_req has been high MEM_TIMEOUT consecutive cycles with no ack, the unit goes DONE with err 11 and res_data=0; mem_req drops.
  - Ack on the timeout edge wins: normal completion.
- MEMU_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; err_code 11 is never produced.

## Test plan
- LB addr=0x1003, rdata=0x80FF_FF_FF: mem_addr=0x1000, mem_be=1111, res_data=0xFFFF_FF80, res_err=0; zero-wait res_valid exactly 2 cycles after accept.
- LHU addr=0x2002, rdata=0xBEEF_1234, ack after 3 wait cycles: res_data=0x0000_BEEF, mem_req high 4 cycles, res_valid 1 cycle.
- SB addr=0x11, wdata=0x1234_56A5: mem_we=1, mem_be=0010, mem_wdata=0xA5A5_A5A5, mem_addr=0x10, res_data=0.
- LW addr=0x6 and op_code=0011: each gives no mem_req, res_valid next cycle, err 01 and 10 respectively.
- With MEMU_TIMEOUT_EN, MEM_TIMEOUT=16, ack never arrives: mem_req high exactly 16 cycles, then res_err=1, err=11. Repeat with ack on cycle 16: normal result.
- rst_n low during REQ of an SW: mem_req falls asynchronously, no res_valid. After release, op_ready=1 and the next LW completes normally.
